sbox_share_sched: RTL

Time-multiplexed scheduler that shares one registered computational AES S-box (one-cycle latency, `sboxaes`) among NREQ requesters, each submitting a 32-bit word for SubWord. It arbitrates between requesters, serializes each word byte-by-byte through the single S-box, and reassembles the substituted word. The block sits between the round datapath / key-expansion logic and the S-box, trading throughput for the area of three extra S-boxes.

---
 rtl/sbox_share_sched_if.sv | 23 ++
 rtl/sbox_share_sched.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/sbox_share_sched_if.sv
// Requester-side bundle for the shared S-box scheduler.
// sbox_in exposes the byte currently presented to the S-box.
interface sbox_share_sched_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [32*NREQ-1:0] req_word;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    rsp_valid;
  logic [31:0]        rsp_word;
  logic               busy;
  logic [7:0]         sbox_in;

  modport master (
    output req_valid, req_word,
    input  req_ready, rsp_valid, rsp_word, busy, sbox_in
  );

  modport slave (
    input  req_valid, req_word,
    output req_ready, rsp_valid, rsp_word, busy, sbox_in
  );
endinterface

// File: rtl/sbox_share_sched.sv
// One registered AES S-box shared by NREQ SubWord requesters.
// SBOX_SHARE_SCHED_RR_EN selects round-robin over fixed priority.
module sboxaes (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);
  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the field inverse, and maps 0 to 0
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] s;
    logic [7:0] r;
    s = gmul(a, a);
    r = s;
    for (int i = 0; i < 6; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] v);
    logic [7:0] o;
    logic [7:0] c;
    c = 8'h63;
    o = '0;
    for (int i = 0; i < 8; i++) begin
      o[i] = v[i] ^ v[(i + 4) % 8] ^ v[(i + 5) % 8]
           ^ v[(i + 6) % 8] ^ v[(i + 7) % 8] ^ c[i];
    end
    return o;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) o_out <= '0;
    else        o_out <= affine(ginv(i_in));
  end
endmodule

module sbox_share_sched #(
  parameter int NREQ = 2
) (
  input logic clk,
  input logic rst_n,
  sbox_share_sched_if.slave bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_idx;
  logic [1:0]      w_cap_idx;
  logic [31:0]     r_word;
  logic [31:0]     r_res;
  logic [31:0]     r_rsp_word;
  logic [31:0]     w_word;
  logic [NREQ-1:0] r_own;
  logic [NREQ-1:0] r_rsp_valid;
  logic [NREQ-1:0] w_grant;
  logic [NREQ-1:0] w_ready;
  logic            w_hit;
  logic            w_acc;
  logic [7:0]      w_sbox_in;
  logic [7:0]      w_sbox_out;

`ifdef SBOX_SHARE_SCHED_RR_EN
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_gidx;
  logic [PW:0]   w_sum;

  // Search starts just past the last winner
  always_comb begin
    w_grant = '0;
    w_gidx  = '0;
    w_hit   = 1'b0;
    w_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k + 1);
      if (w_sum >= (PW+1)'(NREQ))
        w_sum = w_sum - (PW+1)'(NREQ);
      if (!w_hit && bus.req_valid[w_sum[PW-1:0]]) begin
        w_grant[w_sum[PW-1:0]] = 1'b1;
        w_gidx = w_sum[PW-1:0];
        w_hit  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_ptr <= PW'(NREQ - 1);
    else if (w_acc) r_ptr <= w_gidx;
  end
`else
  always_comb begin
    w_grant = '0;
    w_hit   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_hit && bus.req_valid[k]) begin
        w_grant[k] = 1'b1;
        w_hit      = 1'b1;
      end
    end
  end
`endif

  assign w_ready = (rst_n && r_state == S_IDLE) ? w_grant : '0;
  assign w_acc   = |(bus.req_valid & w_ready);

  always_comb begin
    w_word = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_grant[k]) w_word = w_word | bus.req_word[32*k +: 32];
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (w_acc) w_next = S_ISSUE;
      S_ISSUE: if (r_idx == 2'd3) w_next = S_DRAIN;
      S_DRAIN: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  assign w_cap_idx = r_idx - 2'd1;
  assign w_sbox_in = (r_state == S_ISSUE) ?
                     r_word[{r_idx, 3'b000} +: 8] : 8'h00;

  sboxaes u_sbox (
    .clk   (clk),
    .rst_n (rst_n),
    .i_in  (w_sbox_in),
    .o_out (w_sbox_out)
  );

  // S-box output lags the issued byte by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_word      <= '0;
      r_res       <= '0;
      r_own       <= '0;
      r_rsp_valid <= '0;
      r_rsp_word  <= '0;
    end else begin
      r_rsp_valid <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_word <= w_word;
            r_own  <= w_ready;
            r_idx  <= '0;
          end
        end
        S_ISSUE: begin
          r_idx <= r_idx + 2'd1;
          if (r_idx != 2'd0)
            r_res[{w_cap_idx, 3'b000} +: 8] <= w_sbox_out;
        end
        S_DRAIN: begin
          r_res[31:24] <= w_sbox_out;
          r_rsp_valid  <= r_own;
          r_rsp_word   <= {w_sbox_out, r_res[23:0]};
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_word  = r_rsp_word;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.sbox_in   = w_sbox_in;
endmodule
